// File: rtl/mux_pkg.sv
// Shared constants and rotated-priority grant helper for the stream mux
// and its arbiter.
package mux_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_NUM_IN = 4;
    localparam int MAX_IN     = 32;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // One-hot grant of the first set req bit at or after ptr, wrapping modulo n.
    function automatic logic [MAX_IN-1:0] rr_grant(
        input logic [MAX_IN-1:0] req,
        input logic [4:0]        ptr,
        input logic [5:0]        n
    );
        logic [MAX_IN-1:0] g;
        logic              found;
        logic [5:0]        idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_IN; k++) begin
            if (6'(k) < n) begin
                idx = {1'b0, ptr} + 6'(k);
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx[4:0]]) begin
                    g[idx[4:0]] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant logic (round-robin, fixed priority or forced) plus the rotating
// priority pointer.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int  NUM_IN  = DEF_NUM_IN,
    parameter int  RR_MODE = ARB_RR,
    localparam int SEL_W   = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] req,
    input  logic              force_en,
    input  logic [SEL_W-1:0]  force_idx,
    input  logic              advance,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [MAX_IN-1:0] req_ext;
    logic [MAX_IN-1:0] rr_grant_ext;
    logic [NUM_IN-1:0] force_grant;

    always_comb begin
        req_ext             = '0;
        req_ext[NUM_IN-1:0] = req;
    end

    // Fixed priority is the rotating search anchored at index 0.
    assign rr_grant_ext = rr_grant(req_ext,
                                   (RR_MODE == ARB_RR) ? 5'(rr_ptr_q) : 5'd0,
                                   6'(NUM_IN));

    // An out-of-range forced index matches no channel, so nothing is granted.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_force
            assign force_grant[gi] = req[gi] & (force_idx == SEL_W'(gi));
        end
        if (NUM_IN < MAX_IN) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^rr_grant_ext[MAX_IN-1:NUM_IN];
        end
    endgenerate

    assign grant = force_en ? force_grant : rr_grant_ext[NUM_IN-1:0];

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | SEL_W'(i);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/arb_stream_mux.sv
// N-input stream mux: arbitrates one valid channel per cycle into a
// one-entry registered output with valid/ready handshake.
module arb_stream_mux
    import mux_pkg::*;
#(
    parameter int  WIDTH   = DEF_WIDTH,
    parameter int  NUM_IN  = DEF_NUM_IN,
    parameter int  RR_MODE = ARB_RR,
    localparam int SEL_W   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    force_sel_en,
    input  logic [SEL_W-1:0]        force_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_sel
);

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  win_data;
    logic              can_load;
    logic              xfer;

    assign can_load = ~out_valid_q | out_ready;
    // rst_n gates ready so no producer sees a handshake while held in reset.
    assign in_ready = grant & {NUM_IN{can_load & rst_n}};
    assign xfer     = |(in_valid & in_ready);

    rr_arbiter #(
        .NUM_IN  (NUM_IN),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .force_en  (force_sel_en),
        .force_idx (force_sel),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            win_data = win_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data;
            out_sel_d   = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
